// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_pkg
// Description : Shared event codes, FSM state encoding and the fruit index
//               width used by the collision event scheduler and fruit drawers.
// Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

  localparam int FRUIT_IDX_W = 3;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_WALL  = 2'd1,
    EV_FRUIT = 2'd2,
    EV_ROPE  = 2'd3
  } event_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fruit_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : fruit_priority_encoder
// Description : Lowest-set-bit encoder over a fruit mask. Also used by the
//               fruit drawer's selection logic.
// Revision    : 1.0 - initial release
// ============================================================================
module fruit_priority_encoder
  import collision_pkg::*;
#(
  parameter int NUM_FRUITS = 5
) (
  input  logic [NUM_FRUITS-1:0]  mask,
  output logic                   any,
  output logic [FRUIT_IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = |mask;
    idx = '0;
    for (int i = NUM_FRUITS - 1; i >= 0; i--) begin
      if (mask[i]) idx = i[FRUIT_IDX_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_event_scheduler
// Description : Accumulates monkey collisions over a frame, snapshots them at
//               startOfFrame and issues them one by one over valid/ready.
//               Maintains the sticky eaten-fruit mask.
//               Optional macro COLLISION_THRESHOLD_EN: wall/rope hits need
//               PIXEL_THRESHOLD colliding pixels per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_event_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_FRUITS      = 5,
  parameter int PIXEL_THRESHOLD = 8,
  parameter int OVR_W           = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   drawing_request_Ball,
  input  logic                   drawing_request_1,
  input  logic                   drawing_request_Rope,
  input  logic [NUM_FRUITS-1:0]  drawing_request_Fruit,
  input  logic                   fruit_clear,
  input  logic                   event_ready,
  output logic                   event_valid,
  output logic [1:0]             event_type,
  output logic [FRUIT_IDX_W-1:0] event_fruit_idx,
  output logic [NUM_FRUITS-1:0]  fruit_eaten,
  output logic                   rope_contact,
  output logic                   wall_contact,
  output logic [OVR_W-1:0]       overrun_cnt
);

  state_t                   state_q, state_d;
  logic                     cap_wall_q, cap_wall_d, cap_rope_q, cap_rope_d;
  logic [NUM_FRUITS-1:0]    cap_fruit_q, cap_fruit_d;
  logic                     pend_wall_q, pend_wall_d, pend_rope_q, pend_rope_d;
  logic [NUM_FRUITS-1:0]    pend_fruit_q, pend_fruit_d;
  logic                     wall_contact_q, wall_contact_d;
  logic                     rope_contact_q, rope_contact_d;
  logic [NUM_FRUITS-1:0]    fruit_eaten_q, fruit_eaten_d;
  logic [OVR_W-1:0]         overrun_q, overrun_d;

  logic                     px_wall, px_rope, wall_set, rope_set;
  logic [NUM_FRUITS-1:0]    fruit_hit;
  logic                     head_fruit_any;
  logic [FRUIT_IDX_W-1:0]   head_fruit_idx;
  event_t                   head_type;
  logic                     handshake;

  assign px_wall   = drawing_request_Ball & drawing_request_1;
  assign px_rope   = drawing_request_Ball & drawing_request_Rope;
  assign fruit_hit = {NUM_FRUITS{drawing_request_Ball}} & drawing_request_Fruit & ~fruit_eaten_q;

`ifdef COLLISION_THRESHOLD_EN
  localparam int               CNT_W   = $clog2(PIXEL_THRESHOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIXEL_THRESHOLD);

  logic [CNT_W-1:0] wall_cnt_q, wall_cnt_d, rope_cnt_q, rope_cnt_d;
  logic [CNT_W-1:0] wall_base, rope_base;

  // Saturating per-frame pixel counters; the frame-start pixel counts for the new frame.
  always_comb begin
    wall_base  = startOfFrame ? '0 : wall_cnt_q;
    rope_base  = startOfFrame ? '0 : rope_cnt_q;
    wall_cnt_d = (px_wall && wall_base != CNT_MAX) ? wall_base + 1'b1 : wall_base;
    rope_cnt_d = (px_rope && rope_base != CNT_MAX) ? rope_base + 1'b1 : rope_base;
    wall_set   = (wall_cnt_d == CNT_MAX);
    rope_set   = (rope_cnt_d == CNT_MAX);
  end

  // Pixel counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wall_cnt_q <= '0;
      rope_cnt_q <= '0;
    end else begin
      wall_cnt_q <= wall_cnt_d;
      rope_cnt_q <= rope_cnt_d;
    end
  end
`else
  // Any single colliding pixel sets the flag; a non-positive threshold is treated as "never".
  assign wall_set = px_wall & (PIXEL_THRESHOLD > 0);
  assign rope_set = px_rope & (PIXEL_THRESHOLD > 0);
`endif

  fruit_priority_encoder #(
    .NUM_FRUITS (NUM_FRUITS)
  ) u_fruit_enc (
    .mask (pend_fruit_q),
    .any  (head_fruit_any),
    .idx  (head_fruit_idx)
  );

  // Head of the pending set in fixed priority: wall, fruits low-to-high, rope.
  always_comb begin
    head_type = EV_NONE;
    if (pend_wall_q)         head_type = EV_WALL;
    else if (head_fruit_any) head_type = EV_FRUIT;
    else if (pend_rope_q)    head_type = EV_ROPE;
  end

  assign event_valid     = (state_q == ST_ISSUE);
  assign event_type      = event_valid ? head_type : EV_NONE;
  assign event_fruit_idx = (event_valid && head_type == EV_FRUIT) ? head_fruit_idx : '0;
  assign handshake       = event_valid & event_ready;

  // Next-state for capture, pending, eaten mask, contacts, overrun and FSM.
  always_comb begin
    cap_wall_d     = startOfFrame ? wall_set : (cap_wall_q | wall_set);
    cap_rope_d     = startOfFrame ? rope_set : (cap_rope_q | rope_set);
    cap_fruit_d    = startOfFrame ? fruit_hit : (cap_fruit_q | fruit_hit);
    wall_contact_d = startOfFrame ? cap_wall_q : wall_contact_q;
    rope_contact_d = startOfFrame ? cap_rope_q : rope_contact_q;
    overrun_d      = overrun_q;
    fruit_eaten_d  = fruit_eaten_q;

    // Retire the issued item first so a coincident snapshot still overwrites it.
    pend_wall_d  = pend_wall_q & ~(handshake && head_type == EV_WALL);
    pend_rope_d  = pend_rope_q & ~(handshake && head_type == EV_ROPE);
    pend_fruit_d = pend_fruit_q;
    if (handshake && head_type == EV_FRUIT) begin
      pend_fruit_d  = pend_fruit_q & ~(NUM_FRUITS'(1) << head_fruit_idx);
      fruit_eaten_d = fruit_eaten_q | (NUM_FRUITS'(1) << head_fruit_idx);
    end

    if (startOfFrame) begin
      pend_wall_d  = cap_wall_q;
      pend_rope_d  = cap_rope_q;
      pend_fruit_d = cap_fruit_q;
      if (state_q == ST_ISSUE && !(&overrun_q)) overrun_d = overrun_q + 1'b1;
    end

    // Level restart wins over any same-cycle capture, snapshot or eat.
    if (fruit_clear) begin
      cap_fruit_d   = '0;
      pend_fruit_d  = '0;
      fruit_eaten_d = '0;
    end

    state_d = (pend_wall_d || pend_rope_d || (|pend_fruit_d)) ? ST_ISSUE : ST_IDLE;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cap_wall_q     <= 1'b0;
      cap_rope_q     <= 1'b0;
      cap_fruit_q    <= '0;
      pend_wall_q    <= 1'b0;
      pend_rope_q    <= 1'b0;
      pend_fruit_q   <= '0;
      wall_contact_q <= 1'b0;
      rope_contact_q <= 1'b0;
      fruit_eaten_q  <= '0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      cap_wall_q     <= cap_wall_d;
      cap_rope_q     <= cap_rope_d;
      cap_fruit_q    <= cap_fruit_d;
      pend_wall_q    <= pend_wall_d;
      pend_rope_q    <= pend_rope_d;
      pend_fruit_q   <= pend_fruit_d;
      wall_contact_q <= wall_contact_d;
      rope_contact_q <= rope_contact_d;
      fruit_eaten_q  <= fruit_eaten_d;
      overrun_q      <= overrun_d;
    end
  end

  assign fruit_eaten  = fruit_eaten_q;
  assign wall_contact = wall_contact_q;
  assign rope_contact = rope_contact_q;
  assign overrun_cnt  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_event_scheduler
// Description : Directed scoreboard bench for collision_event_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_event_scheduler;
  import collision_pkg::*;

`ifdef COLLISION_THRESHOLD_EN
  localparam int PIX = 8;
`else
  localparam int PIX = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sof, ball, wallpx, ropepx, fruit_clear, ready;
  logic [4:0] fruitpx;
  logic       event_valid;
  logic [1:0] event_type;
  logic [2:0] event_fruit_idx;
  logic [4:0] fruit_eaten;
  logic       rope_contact, wall_contact;
  logic [7:0] overrun_cnt;

  typedef struct packed {
    logic [1:0] t;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  collision_event_scheduler #(
    .NUM_FRUITS      (5),
    .PIXEL_THRESHOLD (8),
    .OVR_W           (8)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .startOfFrame          (sof),
    .drawing_request_Ball  (ball),
    .drawing_request_1     (wallpx),
    .drawing_request_Rope  (ropepx),
    .drawing_request_Fruit (fruitpx),
    .fruit_clear           (fruit_clear),
    .event_ready           (ready),
    .event_valid           (event_valid),
    .event_type            (event_type),
    .event_fruit_idx       (event_fruit_idx),
    .fruit_eaten           (fruit_eaten),
    .rope_contact          (rope_contact),
    .wall_contact          (wall_contact),
    .overrun_cnt           (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input event_t t, input int idx);
    exp_t e;
    e.t   = t;
    e.idx = idx[2:0];
    exp_q.push_back(e);
  endtask

  // Monkey overlapping the given objects for PIX cycles.
  task automatic pixel(input logic w, input logic r, input logic [4:0] f);
    ball = 1'b1; wallpx = w; ropepx = r; fruitpx = f;
    repeat (PIX) tick();
    ball = 1'b0; wallpx = 1'b0; ropepx = 1'b0; fruitpx = '0;
  endtask

  task automatic frame_start();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  // Monitor: each accepted event is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && event_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual type=%0d idx=%0d required=none", event_type, event_fruit_idx);
      end else begin
        e = exp_q.pop_front();
        check("event_type", 32'(event_type), 32'(e.t));
        check("event_fruit_idx", 32'(event_fruit_idx), 32'(e.idx));
      end
    end
  end

  initial begin
    reset = 1'b1; sof = 1'b0; ball = 1'b0; wallpx = 1'b0; ropepx = 1'b0;
    fruitpx = '0; fruit_clear = 1'b0; ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(event_valid), 0);
    check("rst_type", 32'(event_type), 0);
    check("rst_eaten", 32'(fruit_eaten), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    check("rst_contacts", 32'({wall_contact, rope_contact}), 0);
    reset = 1'b0;
    tick();

    // Empty frame: nothing to issue.
    repeat (3) tick();
    frame_start();
    check("empty_valid", 32'(event_valid), 0);
    repeat (3) tick();
    check("empty_valid_later", 32'(event_valid), 0);
    check("empty_overrun", 32'(overrun_cnt), 0);

    // Wall, rope and fruits 1,2 in one frame, consumer always ready.
    ready = 1'b1;
    pixel(1'b1, 1'b1, 5'b00110);
    push(EV_WALL, 0); push(EV_FRUIT, 1); push(EV_FRUIT, 2); push(EV_ROPE, 0);
    frame_start();
    check("first_event_latency", 32'(event_valid), 1);
    repeat (6) tick();
    check("multi_eaten", 32'(fruit_eaten), 32'b00110);
    check("multi_wall_contact", 32'(wall_contact), 1);
    check("multi_rope_contact", 32'(rope_contact), 1);
    check("multi_drained", 32'(event_valid), 0);
    check("multi_queue_empty", 32'(exp_q.size()), 0);

    // Fruit 3 with back-pressure: held stable, then issued once.
    ready = 1'b0;
    pixel(1'b0, 1'b0, 5'b01000);
    frame_start();
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(event_valid), 1);
      check("hold_type", 32'(event_type), 32'(EV_FRUIT));
      check("hold_idx", 32'(event_fruit_idx), 3);
      tick();
    end
    push(EV_FRUIT, 3);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("hold_eaten", 32'(fruit_eaten), 32'b01110);
    check("hold_wall_contact", 32'(wall_contact), 0);
    ready = 1'b1;
    pixel(1'b0, 1'b0, 5'b01000);
    frame_start();
    repeat (3) tick();
    check("eaten_fruit_no_event", 32'(event_valid), 0);

    // Overrun: three pending, stalled across the next frame start.
    ready = 1'b0;
    pixel(1'b1, 1'b1, 5'b00001);
    frame_start();
    pixel(1'b0, 1'b0, 5'b10000);
    frame_start();
    check("overrun_one", 32'(overrun_cnt), 1);
    check("overrun_replaced_type", 32'(event_type), 32'(EV_FRUIT));
    check("overrun_replaced_idx", 32'(event_fruit_idx), 4);
    push(EV_FRUIT, 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("overrun_drained", 32'(event_valid), 0);
    check("overrun_eaten", 32'(fruit_eaten), 32'b11110);
    for (int f = 0; f < 300; f++) begin
      pixel(1'b1, 1'b0, 5'b00000);
      frame_start();
    end
    check("overrun_saturate", 32'(overrun_cnt), 255);
    push(EV_WALL, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    check("saturate_drained", 32'(event_valid), 0);

    // Collision in the frame-start cycle belongs to the next frame.
    ready = 1'b1;
    sof = 1'b1; ball = 1'b1; wallpx = 1'b1;
    tick();
    sof = 1'b0;
    repeat (PIX - 1) tick();
    ball = 1'b0; wallpx = 1'b0;
    check("sof_pixel_excluded", 32'(event_valid), 0);
    check("sof_pixel_contact", 32'(wall_contact), 0);
    repeat (2) tick();
    push(EV_WALL, 0);
    frame_start();
    check("sof_pixel_next_contact", 32'(wall_contact), 1);
    repeat (3) tick();
    check("sof_pixel_issued", 32'(exp_q.size()), 0);

    // fruit_clear coincident with a fruit-0 handshake.
    ready = 1'b0;
    pixel(1'b0, 1'b0, 5'b00001);
    frame_start();
    check("clear_head_idx", 32'(event_fruit_idx), 0);
    check("clear_head_type", 32'(event_type), 32'(EV_FRUIT));
    push(EV_FRUIT, 0);
    ready = 1'b1; fruit_clear = 1'b1;
    tick();
    ready = 1'b0; fruit_clear = 1'b0;
    tick();
    check("clear_eaten", 32'(fruit_eaten), 0);
    check("clear_idle", 32'(event_valid), 0);

`ifdef COLLISION_THRESHOLD_EN
    // Threshold: 7 wall pixels are not enough, 8 are.
    ready = 1'b1;
    ball = 1'b1; wallpx = 1'b1;
    repeat (7) tick();
    ball = 1'b0; wallpx = 1'b0;
    frame_start();
    repeat (3) tick();
    check("thresh_seven", 32'(event_valid), 0);
    pixel(1'b1, 1'b0, 5'b00000);
    push(EV_WALL, 0);
    frame_start();
    repeat (3) tick();
    check("thresh_eight", 32'(exp_q.size()), 0);
`endif

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
